// File: rtl/oled_task_scheduler.sv
// Frame-synchronous owner scheduler for the OLED, 7-seg and LEDs.
// Debounces the switch request, then hands over on frame boundaries with blank frames in between.
module oled_task_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned BLANK_FRAMES    = 2,
    parameter logic [15:0] BLANK_COLOUR    = 16'h0000
) (
    input  logic        basys_clk,
    input  logic        reset,
    input  logic [5:1]  SW,
    input  logic        frame_begin,
    input  logic [15:0] oled_data_a,
    input  logic [15:0] oled_data_b,
    input  logic [15:0] oled_data_c,
    input  logic [15:0] oled_data_d,
    input  logic [15:0] oled_data_group,
    input  logic [6:0]  seg_e,
    input  logic [3:0]  an_e,
    input  logic        dp_e,
    output logic [15:0] oled_data,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic [15:0] led,
    output logic [4:0]  task_start,
    output logic        busy
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLANK_FRAMES - 1);

    typedef enum logic [1:0] {
        RUN,
        DEBNC,
        WAIT_FB,
        BLANK
    } state_t;

    state_t        state, state_d;
    logic [2:0]    cur_sel, cur_sel_d;
    logic [2:0]    cand, cand_d;
    logic [DW-1:0] dcnt, dcnt_d;
    logic [FW-1:0] fcnt, fcnt_d;
    logic [2:0]    req;
    logic [4:0]    start_d;
    logic [15:0]   pix_d;
    logic [15:0]   led_d;
    logic [6:0]    seg_d;
    logic [3:0]    an_d;
    logic          dp_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        req = 3'd0;
        if (SW[5])      req = 3'd5;
        else if (SW[4]) req = 3'd4;
        else if (SW[3]) req = 3'd3;
        else if (SW[2]) req = 3'd2;
        else if (SW[1]) req = 3'd1;
    end

    always_comb begin
        state_d   = state;
        cur_sel_d = cur_sel;
        cand_d    = cand;
        dcnt_d    = dcnt;
        fcnt_d    = fcnt;
        start_d   = '0;
        case (state)
            RUN: begin
                if (req != cur_sel) begin
                    state_d = DEBNC;
                    cand_d  = req;
                    dcnt_d  = '0;
                end
            end
            DEBNC: begin
                if (req == cur_sel) begin
                    state_d = RUN;
                end else if (req != cand) begin
                    cand_d = req;
                    dcnt_d = '0;
                end else if (dcnt == DCNT_LAST) begin
                    state_d = WAIT_FB;
                end else begin
                    dcnt_d = dcnt + DW'(1);
                end
            end
            WAIT_FB: begin
                if (frame_begin) begin
                    state_d = BLANK;
                    fcnt_d  = '0;
                end
            end
            BLANK: begin
                if (frame_begin) begin
                    if (fcnt == FCNT_LAST) begin
                        state_d   = RUN;
                        cur_sel_d = cand;
                        if (cand != 3'd0) start_d = 5'd1 << (cand - 3'd1);
                    end else begin
                        fcnt_d = fcnt + FW'(1);
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Port values derived from the current owner; blanking overrides everything.
    always_comb begin
        case (cur_sel)
            3'd1:    pix_d = oled_data_a;
            3'd2:    pix_d = oled_data_b;
            3'd3:    pix_d = oled_data_c;
            3'd4:    pix_d = oled_data_d;
            3'd5:    pix_d = oled_data_group;
            default: pix_d = BLANK_COLOUR;
        endcase
        led_d = '0;
        seg_d = 7'h7F;
        an_d  = 4'hF;
        dp_d  = 1'b1;
        if (state == BLANK) begin
            pix_d = BLANK_COLOUR;
        end else begin
            if (cur_sel != 3'd0) led_d = 16'd1 << (cur_sel - 3'd1);
            if (cur_sel == 3'd5) begin
                seg_d = seg_e;
                an_d  = an_e;
                dp_d  = dp_e;
            end
        end
    end

    always_ff @(posedge basys_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= RUN;
            cur_sel    <= 3'd0;
            cand       <= 3'd0;
            dcnt       <= '0;
            fcnt       <= '0;
            oled_data  <= BLANK_COLOUR;
            led        <= '0;
            seg        <= 7'h7F;
            an         <= 4'hF;
            dp         <= 1'b1;
            task_start <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cur_sel    <= cur_sel_d;
            cand       <= cand_d;
            dcnt       <= dcnt_d;
            fcnt       <= fcnt_d;
            oled_data  <= pix_d;
            led        <= led_d;
            seg        <= seg_d;
            an         <= an_d;
            dp         <= dp_d;
            task_start <= start_d;
            busy       <= (state != RUN);
        end
    end

endmodule

// File: tb/tb_oled_task_scheduler.sv
// Directed bench for oled_task_scheduler: debounce, frame-aligned handover, blanking, priority, reset.
// Inputs change and outputs are sampled 1 ns after the rising edge; frame_begin changes on falling edges.
module tb_oled_task_scheduler;

    localparam logic [15:0] PIX_A = 16'hA1A1;
    localparam logic [15:0] PIX_B = 16'hB2B2;
    localparam logic [15:0] PIX_C = 16'hC3C3;
    localparam logic [15:0] PIX_D = 16'hD4D4;
    localparam logic [15:0] PIX_G = 16'hE5E5;

    logic        basys_clk = 1'b0;
    logic        reset;
    logic [5:1]  SW;
    logic        frame_begin;
    logic [15:0] oled_data_a, oled_data_b, oled_data_c, oled_data_d, oled_data_group;
    logic [6:0]  seg_e;
    logic [3:0]  an_e;
    logic        dp_e;
    logic [15:0] oled_data;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic [15:0] led;
    logic [4:0]  task_start;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    oled_task_scheduler #(
        .DEBOUNCE_CYCLES(4),
        .BLANK_FRAMES   (2),
        .BLANK_COLOUR   (16'h0000)
    ) dut (
        .basys_clk      (basys_clk),
        .reset          (reset),
        .SW             (SW),
        .frame_begin    (frame_begin),
        .oled_data_a    (oled_data_a),
        .oled_data_b    (oled_data_b),
        .oled_data_c    (oled_data_c),
        .oled_data_d    (oled_data_d),
        .oled_data_group(oled_data_group),
        .seg_e          (seg_e),
        .an_e           (an_e),
        .dp_e           (dp_e),
        .oled_data      (oled_data),
        .seg            (seg),
        .an             (an),
        .dp             (dp),
        .led            (led),
        .task_start     (task_start),
        .busy           (busy)
    );

    always #5 basys_clk = ~basys_clk;

    // One-cycle frame pulse every 50 cycles.
    initial begin
        frame_begin = 1'b0;
        forever begin
            repeat (49) @(negedge basys_clk);
            frame_begin = 1'b1;
            @(negedge basys_clk);
            frame_begin = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge basys_clk);
        #1;
    endtask

    // Advance until an edge that sampled frame_begin high; bounded to just over one frame.
    task automatic wait_fb();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (frame_begin) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b1) begin
            tests_failed++;
            $display("FAIL wait_fb: frame pulse absent for 60 cycles");
        end
    endtask

    // Full handover: request, debounce, wait for frame, two blank frames, start pulse, new owner.
    task automatic switch_owner(input logic [5:1] sw, input logic [5:1] sw_in_blank,
                                input logic [4:0] exp_start, input logic [15:0] exp_led,
                                input logic [15:0] exp_pix, input logic [15:0] old_pix);
        SW = sw;
        tick();
        tick();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL switch_busy: busy=%b expected 1", busy);
        end
        repeat (3) tick();
        wait_fb();
        tests_run++;
        if (task_start !== 5'b0 || oled_data !== old_pix) begin
            tests_failed++;
            $display("FAIL switch_first_fb: task_start=%b oled=%h expected 00000 %h",
                     task_start, oled_data, old_pix);
        end
        SW = sw_in_blank;
        wait_fb();
        tests_run++;
        if (oled_data !== 16'h0000 || led !== 16'h0 || task_start !== 5'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL switch_blank: oled=%h led=%h start=%b busy=%b expected 0000 0000 00000 1",
                     oled_data, led, task_start, busy);
        end
        wait_fb();
        tests_run++;
        if (task_start !== exp_start) begin
            tests_failed++;
            $display("FAIL switch_start: task_start=%b expected %b", task_start, exp_start);
        end
        tick();
        tests_run++;
        if (task_start !== 5'b0 || led !== exp_led || oled_data !== exp_pix || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL switch_owner: start=%b led=%h oled=%h busy=%b expected 00000 %h %h 0",
                     task_start, led, oled_data, busy, exp_led, exp_pix);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        SW    = 5'b0;
        repeat (3) tick();
        tests_run++;
        if (oled_data !== 16'h0 || led !== 16'h0 || seg !== 7'h7F || an !== 4'hF || dp !== 1'b1
            || busy !== 1'b0 || task_start !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: oled=%h led=%h seg=%h an=%h dp=%b busy=%b start=%b",
                     oled_data, led, seg, an, dp, busy, task_start);
        end
        reset = 1'b0;
        repeat (5) tick();
        tests_run++;
        if (oled_data !== 16'h0 || led !== 16'h0 || seg !== 7'h7F || busy !== 1'b0 || task_start !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: oled=%h led=%h seg=%h busy=%b start=%b",
                     oled_data, led, seg, busy, task_start);
        end
    endtask

    task automatic test_first_owner();
        switch_owner(5'b00001, 5'b00001, 5'b00001, 16'h0001, PIX_A, 16'h0000);
    endtask

    task automatic test_glitch_abort();
        int bad;
        SW = 5'b00010;
        tick();
        tick();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL glitch_debounce: busy=%b expected 1", busy);
        end
        SW = 5'b00001;
        tick();
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (busy !== 1'b0 || task_start !== 5'b0 || oled_data !== PIX_A || led !== 16'h0001) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL glitch_abort: %0d bad cycles, expected 0 (busy=%b start=%b oled=%h led=%h)",
                     bad, busy, task_start, oled_data, led);
        end
    endtask

    task automatic test_group_priority();
        tests_run++;
        if (seg !== 7'h7F || an !== 4'hF || dp !== 1'b1) begin
            tests_failed++;
            $display("FAIL seg_off_for_a: seg=%h an=%h dp=%b expected 7f f 1", seg, an, dp);
        end
        switch_owner(5'b10010, 5'b10010, 5'b10000, 16'h0010, PIX_G, PIX_A);
        tests_run++;
        if (seg !== 7'h12 || an !== 4'h5 || dp !== 1'b0) begin
            tests_failed++;
            $display("FAIL seg_group: seg=%h an=%h dp=%b expected 12 5 0", seg, an, dp);
        end
        seg_e = 7'h34;
        tick();
        tests_run++;
        if (seg !== 7'h34) begin
            tests_failed++;
            $display("FAIL seg_follow: seg=%h expected 34", seg);
        end
    endtask

    task automatic test_frame_exact();
        int old_bad;
        int blank_n;
        logic [4:0] last_start;
        bit seen;
        wait_fb();
        repeat (20) tick();
        SW = 5'b00010;
        old_bad = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (oled_data !== PIX_G) old_bad++;
            if (frame_begin) seen = 1'b1;
        end
        tests_run++;
        if (old_bad !== 0 || seen !== 1'b1) begin
            tests_failed++;
            $display("FAIL old_pixels: %0d non-group cycles, fb_seen=%b expected 0 1", old_bad, seen);
        end
        blank_n = 0;
        last_start = 5'b0;
        tick();
        for (int i = 0; i < 200 && oled_data === 16'h0000; i++) begin
            blank_n++;
            last_start = task_start;
            tick();
        end
        tests_run++;
        if (blank_n !== 100) begin
            tests_failed++;
            $display("FAIL blank_length: %0d blank cycles expected 100", blank_n);
        end
        tests_run++;
        if (last_start !== 5'b00010 || oled_data !== PIX_B || led !== 16'h0002 || seg !== 7'h7F) begin
            tests_failed++;
            $display("FAIL frame_new_owner: start=%b oled=%h led=%h seg=%h expected 00010 %h 0002 7f",
                     last_start, oled_data, led, seg, PIX_B);
        end
    endtask

    task automatic test_ignore_in_blank();
        switch_owner(5'b01000, 5'b00100, 5'b01000, 16'h0008, PIX_D, PIX_B);
        tick();
        tests_run++;
        if (busy !== 1'b1 || oled_data !== PIX_D) begin
            tests_failed++;
            $display("FAIL restart_debounce: busy=%b oled=%h expected 1 %h", busy, oled_data, PIX_D);
        end
        repeat (3) tick();
        wait_fb();
        wait_fb();
        wait_fb();
        tests_run++;
        if (task_start !== 5'b00100) begin
            tests_failed++;
            $display("FAIL start_c: task_start=%b expected 00100", task_start);
        end
        tick();
        tests_run++;
        if (led !== 16'h0004 || oled_data !== PIX_C || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL owner_c: led=%h oled=%h busy=%b expected 0004 %h 0", led, oled_data, busy, PIX_C);
        end
    endtask

    task automatic test_reset_mid_blank();
        int bad;
        SW = 5'b00001;
        repeat (5) tick();
        wait_fb();
        repeat (10) tick();
        tests_run++;
        if (oled_data !== 16'h0000 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL in_blank: oled=%h busy=%b expected 0000 1", oled_data, busy);
        end
        reset = 1'b1;
        SW    = 5'b0;
        tick();
        tests_run++;
        if (oled_data !== 16'h0 || led !== 16'h0 || seg !== 7'h7F || an !== 4'hF || dp !== 1'b1
            || busy !== 1'b0 || task_start !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_blank: oled=%h led=%h seg=%h an=%h dp=%b busy=%b start=%b",
                     oled_data, led, seg, an, dp, busy, task_start);
        end
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (task_start !== 5'b0 || oled_data !== 16'h0 || led !== 16'h0 || busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: %0d bad cycles expected 0", bad);
        end
    endtask

    initial begin
        reset           = 1'b1;
        SW              = 5'b0;
        oled_data_a     = PIX_A;
        oled_data_b     = PIX_B;
        oled_data_c     = PIX_C;
        oled_data_d     = PIX_D;
        oled_data_group = PIX_G;
        seg_e           = 7'h12;
        an_e            = 4'h5;
        dp_e            = 1'b0;

        test_reset();
        test_first_owner();
        test_glitch_abort();
        test_group_priority();
        test_frame_exact();
        test_ignore_in_blank();
        test_reset_mid_blank();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
